// File: rtl/gray_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_seq_counter
//  Description : Registered Gray-code sequence generator. An internal binary
//                count is stepped up or down, loaded, wrapped or saturated,
//                and presented as Gray code so that every counting step flips
//                exactly one bit of g. Drives the g input of a downstream
//                Gray-to-binary converter; bin is the matching golden value.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                en       - count enable (one step per clock while high)
//                up_dn    - direction, 1 = up, 0 = down
//                load     - synchronous load strobe (highest priority)
//                load_val - binary value captured on load
//                g        - registered Gray-code count
//                bin      - registered binary count
//                tc       - combinational terminal-count flag
//                sat      - registered flag, last enabled step was blocked
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_seq_counter #(
   parameter int WIDTH = 4,   // count width, 2..16
   parameter int WRAP  = 1    // 1 = wrap at end of range, 0 = saturate
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] bin,
   output logic             tc,
   output logic             sat
);

   localparam logic [WIDTH-1:0] c_zero     = '0;
   localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_all_ones = '1;
   localparam logic             c_wrap_en  = (WRAP != 0);

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_sat;

   logic             w_at_max;
   logic             w_at_min;
   logic [WIDTH-1:0] w_bin_next;
   logic [WIDTH-1:0] w_gray_next;
   logic             w_sat_next;

   assign w_at_max = (r_bin == c_all_ones);
   assign w_at_min = (r_bin == c_zero);

   // Next-count selection: load beats counting, idle holds everything.
   // The modulo-2^WIDTH add/subtract already produces the wrap values, so the
   // end-of-range case only has to decide between stepping and holding.
   always_comb begin
      w_bin_next = r_bin;
      w_sat_next = r_sat;
      if (load) begin
         w_bin_next = load_val;
         w_sat_next = 1'b0;
      end else if (en) begin
         if (up_dn) begin
            if (!w_at_max || c_wrap_en) begin
               w_bin_next = r_bin + c_one;
               w_sat_next = 1'b0;
            end else begin
               w_sat_next = 1'b1;
            end
         end else begin
            if (!w_at_min || c_wrap_en) begin
               w_bin_next = r_bin - c_one;
               w_sat_next = 1'b0;
            end else begin
               w_sat_next = 1'b1;
            end
         end
      end
   end

   // Gray is derived from the next binary value so g and bin share one edge.
   assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= c_zero;
         r_gray <= c_zero;
         r_sat  <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_sat  <= w_sat_next;
      end
   end

   // Flags the cycle before a wrap or saturate edge.
   assign tc  = en & ~load & ((up_dn & w_at_max) | (~up_dn & w_at_min));

   assign g   = r_gray;
   assign bin = r_bin;
   assign sat = r_sat;

endmodule
`default_nettype wire

// File: doc/gray_seq_counter.md
Name: gray_seq_counter

Overview:
- Registered Gray-code sequence generator that sits directly upstream of the Gray-to-binary converter and drives its `g` input.
- Keeps an internal binary count and presents it as Gray code, so each step changes exactly one output bit.
- Supports up/down counting, synchronous load, wrap or saturate at the end of the range, and a terminal-count flag.
- The bench checks the downstream converter's `b` output against this block's `bin` output.

Parameters:
- WIDTH, 4, count width in bits; legal values 2..16.
- WRAP, 1, end-of-range policy: 1 wraps around, 0 saturates (holds at the end value).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; the count steps once per clock while high.
- up_dn  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value captured on load.
- g  output  WIDTH  registered Gray-code count; connects to the converter's `g`.
- bin  output  WIDTH  registered binary count, the golden reference for the converter.
- tc  output  1  combinational terminal-count flag.
- sat  output  1  registered flag: the last enabled step was blocked by saturation.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (`rst_n`).
- While `rst_n` is low: `bin`=0, `g`=0, `sat`=0, `tc` follows its combinational rule.
- Release of `rst_n` is sampled on the next rising edge of `clk`.
- Gray encoding: `g` is registered from the next binary value, g_next = bin_next ^ (bin_next >> 1).
  - `g` and `bin` therefore update on the same edge and are never skewed.
- Priority at each rising edge:
  1. `load`=1: bin <= load_val and g <= Gray(load_val). `en` and `up_dn` are ignored. sat <= 0.
  2. Else `en`=1 and up_dn=1:
     - bin != all-ones: bin <= bin+1, sat <= 0.
     - bin == all-ones and WRAP=1: bin <= 0, sat <= 0.
     - bin == all-ones and WRAP=0: bin holds, sat <= 1.
  3. Else `en`=1 and up_dn=0:
     - bin != 0: bin <= bin-1, sat <= 0.
     - bin == 0 and WRAP=1: bin <= all-ones, sat <= 0.
     - bin == 0 and WRAP=0: bin holds, sat <= 1.
  4. Else (idle): all registers hold, including `sat`.
- Arithmetic: all counting is modulo 2^WIDTH. No carry out; no X propagation from unused bits.
- Latency: `g` and `bin` reflect a step or load one cycle after the sampling edge.
- tc = en & ~load & ((up_dn & bin==all-ones) | (~up_dn & bin==0)).
  - `tc` is combinational and is valid in the cycle before the wrap or saturate edge.
- Single-bit-change invariant: on every enabled non-load step that is not saturated, popcount(g_old ^ g_new) == 1. This includes the wrap steps (all-ones to 0 and 0 to all-ones).
- Load may move `g` by any number of bits; the invariant does not apply to load steps.
- Direction change: `up_dn` may toggle on any cycle and takes effect on the same edge; no pipeline to flush.
- `load` with `en`=0 still loads.
- Reset mid-count: asserting `rst_n` low forces 0 immediately, without waiting for a clock edge. The count resumes from 0 with no residual `sat`.
- Outputs are fully registered except `tc`. No combinational path from `load_val` to `g` or `bin`.

Test Plan:
- Reset, then en=1, up_dn=1, WRAP=1, 16 clocks:
  - `g` steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then back to 0.
  - `bin` steps 0..F; `tc`=1 only while bin=F.
  - The converter's `b` equals `bin` every cycle.
- From bin=0, en=1, up_dn=0, WRAP=1:
  - Next values bin=F, g=8, then bin=E, g=9.
  - `tc`=1 in the cycle where bin=0; popcount(g delta)=1 on every step.
- WRAP=0, load_val=E with load=1, then en=1, up_dn=1 for 3 clocks:
  - bin=F, g=8, then stays at F.
  - `sat`=1 from the second enabled edge onward.
  - Then up_dn=0 for 1 clock: bin=E, sat=0.
- load=1 and en=1 together with load_val=9 while counting up from 3: next bin=9, g=D; `tc`=0 during the load cycle.
- Count to bin=6 (g=5), then pull rst_n low mid-cycle:
  - `g`=0, `bin`=0, `sat`=0 before the next clock edge.
  - After release, counting restarts 1,2,...
- Random en/up_dn/load for 1000 cycles:
  - Scoreboard checks that `g` is always Gray(`bin`).
  - Every non-load, non-saturated enabled step changes exactly one bit of `g`.
  - Converter output matches `bin`.
